ex_div_unit: RTL

Multi-cycle RV64M integer divider in the EX stage, directly downstream of the forwarding unit. It takes the forwarded rs1/rs2 operands of DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW, runs a radix-2 restoring division, and returns a 64-bit result. While the division runs it raises a stall request toward the hazard/pipeline control.

---
 rtl/ex_div_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ex_div_unit.sv
// Multi-cycle RV64M divider for the EX stage: radix-2 restoring division of the
// forwarded rs1/rs2 operands, with a stall request while the iteration runs.
module ex_div_unit (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        DivValidIn,
    input  logic [2:0]  DivOpIn,
    input  logic [63:0] Rs1DataIn,
    input  logic [63:0] Rs2DataIn,
    input  logic        FlushIn,
    output logic        DivReadyOut,
    output logic        DivBusyOut,
    output logic        ResultValidOut,
    output logic [63:0] ResultDataOut
);
    // state | meaning
    // IDLE  | waiting for a divide instruction
    // CALC  | one quotient bit per cycle, count runs down to 1
    // DONE  | result pulse cycle, pipeline advances
    localparam int DataBus = 64;

    typedef enum logic [1:0] {IDLE, CALC, DONE} divState_t;

    divState_t          state;
    logic [DataBus-1:0] remReg;
    logic [DataBus-1:0] quoReg;
    logic [DataBus-1:0] divisorReg;
    logic [6:0]         count;
    logic               negQReg;
    logic               negRReg;
    logic               remOpReg;
    logic               wordReg;

    logic               opUnsigned;
    logic               opRem;
    logic               opWord;
    logic [DataBus-1:0] dividendExt;
    logic [DataBus-1:0] divisorExt;
    logic               signA;
    logic               signB;
    logic [DataBus-1:0] absA;
    logic [DataBus-1:0] absB;
    logic               divByZero;
    logic               overflow;
    logic [DataBus-1:0] specSel;
    logic [DataBus-1:0] specFinal;

    logic [DataBus:0]   shifted;
    logic [DataBus:0]   diff;
    logic [DataBus-1:0] remNext;
    logic [DataBus-1:0] quoNext;
    logic [DataBus-1:0] quoRaw;
    logic [DataBus-1:0] quoFix;
    logic [DataBus-1:0] remFix;
    logic [DataBus-1:0] calcSel;
    logic [DataBus-1:0] calcFinal;

    assign opUnsigned = DivOpIn[0];
    assign opRem      = DivOpIn[1];
    assign opWord     = DivOpIn[2];

    always_comb begin
        dividendExt = Rs1DataIn;
        divisorExt  = Rs2DataIn;
        if (opWord) begin
            dividendExt = opUnsigned ? {32'b0, Rs1DataIn[31:0]} : {{32{Rs1DataIn[31]}}, Rs1DataIn[31:0]};
            divisorExt  = opUnsigned ? {32'b0, Rs2DataIn[31:0]} : {{32{Rs2DataIn[31]}}, Rs2DataIn[31:0]};
        end
    end

    assign signA     = !opUnsigned && dividendExt[DataBus-1];
    assign signB     = !opUnsigned && divisorExt[DataBus-1];
    assign absA      = signA ? -dividendExt : dividendExt;
    assign absB      = signB ? -divisorExt : divisorExt;
    assign divByZero = (divisorExt == '0);
    assign overflow  = !opUnsigned && (divisorExt == '1) &&
                       (dividendExt == (opWord ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

    // Special cases bypass the iteration and resolve entirely at accept.
    always_comb begin
        specSel = '0;
        if (divByZero)
            specSel = opRem ? dividendExt : '1;
        else if (overflow)
            specSel = opRem ? '0 : dividendExt;
        specFinal = opWord ? {{32{specSel[31]}}, specSel[31:0]} : specSel;
    end

    // Shifted remainder can reach 65 bits when the divisor uses bit 63.
    assign shifted = {remReg, quoReg[DataBus-1]};
    assign diff    = shifted - {1'b0, divisorReg};
    assign remNext = diff[DataBus] ? shifted[DataBus-1:0] : diff[DataBus-1:0];
    assign quoNext = {quoReg[DataBus-2:0], ~diff[DataBus]};

    always_comb begin
        quoRaw    = wordReg ? {32'b0, quoNext[31:0]} : quoNext;
        quoFix    = negQReg ? -quoRaw : quoRaw;
        remFix    = negRReg ? -remNext : remNext;
        calcSel   = remOpReg ? remFix : quoFix;
        calcFinal = wordReg ? {{32{calcSel[31]}}, calcSel[31:0]} : calcSel;
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state          <= IDLE;
            remReg         <= '0;
            quoReg         <= '0;
            divisorReg     <= '0;
            count          <= '0;
            negQReg        <= 1'b0;
            negRReg        <= 1'b0;
            remOpReg       <= 1'b0;
            wordReg        <= 1'b0;
            ResultValidOut <= 1'b0;
            ResultDataOut  <= '0;
        end else begin
            ResultValidOut <= 1'b0;
            if (FlushIn) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (DivValidIn) begin
                            remReg     <= '0;
                            quoReg     <= opWord ? {absA[31:0], 32'b0} : absA;
                            divisorReg <= absB;
                            count      <= opWord ? 7'd32 : 7'd64;
                            negQReg    <= signA ^ signB;
                            negRReg    <= signA;
                            remOpReg   <= opRem;
                            wordReg    <= opWord;
                            if (divByZero || overflow) begin
                                state          <= DONE;
                                ResultValidOut <= 1'b1;
                                ResultDataOut  <= specFinal;
                            end else begin
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        remReg <= remNext;
                        quoReg <= quoNext;
                        count  <= count - 7'd1;
                        if (count == 7'd1) begin
                            state          <= DONE;
                            ResultValidOut <= 1'b1;
                            ResultDataOut  <= calcFinal;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign DivReadyOut = (state == IDLE);
    assign DivBusyOut  = ((state == IDLE) && DivValidIn && !FlushIn) || (state == CALC);

endmodule
